rx_fifo_reg: RTL and testbench
==============================

Name: rx_fifo_reg

Overview:
Parametrised receive data FIFO. Successor to the single-byte receive data register.
- Sits between the USRT receive shifter (push side) and the CPU/peripheral bus (pop side), in the i_Pclk domain.
- Buffers up to DEPTH words, reports fill level and a programmable threshold.
- Flags overrun when the shifter delivers a word into a full FIFO.

Parameters:
DATA_W, 8, width of each data word
DEPTH, 4, number of entries; power of two, minimum 2
THRESH, 2, o_Thresh asserts when level >= THRESH; range 1..DEPTH

Ports:
i_Pclk  in  1  system clock; all state updates on its rising edge
i_Reset_n  in  1  asynchronous active-low reset
i_Push  in  1  write strobe from the receive shifter, one word per cycle
i_Data  in  DATA_W  word to write, sampled when i_Push=1
i_Pop  in  1  read strobe from the bus side; advances the head
o_Data  out  DATA_W  head word (first-word-fall-through); valid only while o_Empty=0
o_Full  out  1  level == DEPTH
o_Empty  out  1  level == 0
o_Level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH
o_Thresh  out  1  level >= THRESH
o_Overrun  out  1  sticky overrun flag
i_ClrOvr  in  1  one-cycle pulse; clears o_Overrun

Behaviour:
- Reset (i_Reset_n=0, asynchronous, any time):
  - rd/wr pointers = 0, level = 0, o_Overrun = 0.
  - Resulting outputs: o_Empty = 1, o_Full = 0, o_Thresh = 0, o_Level = 0, o_Data = 0.
  - Storage array is not reset. o_Data is forced to 0 while empty.
  - Reset mid-operation discards all contents.
- Storage: DEPTH x DATA_W register array.
- Pointers: clog2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Push accepted iff i_Push and (not full, or i_Pop accepted in the same cycle).
  - The word is written at wr_ptr and wr_ptr increments at the edge.
  - It is visible on o_Data the cycle after the edge if the FIFO was empty.
- Pop accepted iff i_Pop and not empty. rd_ptr increments at the edge.
  - o_Data shows the next entry, or 0 if the FIFO is now empty, in the following cycle.
- Pop when empty: ignored. No state change.
- Push when full without an accepted pop:
  - Word is dropped; existing contents are unchanged.
  - o_Overrun is set at the edge.
- Push and pop together:
  - Not empty (including full): both accepted, level unchanged, no overrun.
  - Empty: push accepted, pop ignored, level becomes 1.
- Level update per edge:
  - +1 on push-only accepted.
  - -1 on pop-only accepted.
  - Unchanged otherwise.
  - o_Full, o_Empty and o_Thresh are decoded from the registered level; there is no extra latency beyond the level register.
- o_Overrun is sticky.
  - i_ClrOvr clears it.
  - If i_ClrOvr and a new overrun occur in the same cycle, set wins.
- Latency: push to o_Empty=0 is 1 cycle. Pop to next word on o_Data is 1 cycle.

Optional Feature:
RX_FIFO_UNDERRUN_EN
- Defined:
  - Adds output o_Underrun (1 bit, sticky, reset 0).
  - Set on any i_Pop while o_Empty=1, except when a push is accepted in the same cycle on an empty FIFO.
  - Cleared by i_ClrOvr, with set winning on a simultaneous event.
- Undefined: port is absent; pop-when-empty is silently ignored.

Decomposition:
- Package rx_fifo_pkg holds:
  - default constants DATA_W_DEF=8, DEPTH_DEF=4, THRESH_DEF=2;
  - a level-width function clog2(DEPTH)+1.
- Sub-module rx_fifo_ctrl holds:
  - pointers, level counter, accept logic, flag decode, overrun/underrun logic.
  - The top level instantiates it plus the storage array and output mux.

Test Plan:
- Reset then idle -> o_Empty=1, o_Full=0, o_Level=0, o_Data=8'h00, o_Overrun=0.
- DEPTH=4, push 8'h2E, 8'h11 on consecutive cycles:
  - o_Data=8'h2E one cycle after the first push; o_Level=2; o_Thresh=1.
  - Pop twice -> o_Data=8'h11, then o_Empty=1.
- Push 8'hA1,8'hA2,8'hA3,8'hA4 -> o_Full=1, o_Level=4.
  - Push 8'hFF -> o_Overrun=1, o_Level=4.
  - Pops return A1..A4 (FF never appears).
  - Pulse i_ClrOvr -> o_Overrun=0.
- Full FIFO (B0..B3), simultaneous push 8'hC4 and pop -> o_Level stays 4, o_Overrun=0.
  - Subsequent pops return B1,B2,B3,C4 (pointer wrap verified).
- Empty FIFO, simultaneous push 8'h5A and pop -> o_Level=1, o_Data=8'h5A.
  - With RX_FIFO_UNDERRUN_EN: o_Underrun stays 0. A pop on the then-empty FIFO sets o_Underrun=1.
- Push 3 words, assert i_Reset_n=0 mid-clock -> o_Empty=1, o_Level=0 immediately, without waiting for a clock edge.
  - After release, push 8'h77 -> o_Data=8'h77.

Source files
------------

// File: rtl/rx_fifo_pkg.sv
// Shared constants and helpers for the receive FIFO.
// Optional build macro used by this slice: RX_FIFO_UNDERRUN_EN.
package rx_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int THRESH_DEF = 2;

    // Level must encode 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rx_fifo_ctrl.sv
// Receive FIFO control: pointers, occupancy, accept logic, flag decode and sticky error flags.
// Define RX_FIFO_UNDERRUN_EN to add the sticky o_Underrun flag.
module rx_fifo_ctrl
    import rx_fifo_pkg::*;
#(
    parameter  int DEPTH  = DEPTH_DEF,
    parameter  int THRESH = THRESH_DEF,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int LVL_W  = level_w(DEPTH)
) (
    input  logic             i_Pclk,
    input  logic             i_Reset_n,
    input  logic             i_Push,
    input  logic             i_Pop,
    input  logic             i_ClrOvr,
    output logic             o_WrEn,
    output logic [PTR_W-1:0] o_WrPtr,
    output logic [PTR_W-1:0] o_RdPtr,
    output logic             o_Full,
    output logic             o_Empty,
    output logic [LVL_W-1:0] o_Level,
    output logic             o_Thresh,
`ifdef RX_FIFO_UNDERRUN_EN
    output logic             o_Underrun,
`endif
    output logic             o_Overrun
);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overrun;

    logic w_full;
    logic w_empty;
    logic w_push_acc;
    logic w_pop_acc;
    logic w_ovr_set;

    assign w_full     = (r_level == LVL_W'(DEPTH));
    assign w_empty    = (r_level == '0);
    assign w_pop_acc  = i_Pop && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a word.
    assign w_push_acc = i_Push && (!w_full || w_pop_acc);
    assign w_ovr_set  = i_Push && !w_push_acc;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push_acc && !w_pop_acc)
                r_level <= r_level + LVL_W'(1);
            else if (w_pop_acc && !w_push_acc)
                r_level <= r_level - LVL_W'(1);
            r_overrun <= w_ovr_set || (r_overrun && !i_ClrOvr);
        end
    end

`ifdef RX_FIFO_UNDERRUN_EN
    logic r_underrun;
    logic w_udr_set;

    // A push into an empty FIFO supplies the word, so the concurrent pop is not an underrun.
    assign w_udr_set = i_Pop && w_empty && !w_push_acc;

    always_ff @(posedge i_Pclk or negedge i_Reset_n) begin
        if (!i_Reset_n) r_underrun <= 1'b0;
        else            r_underrun <= w_udr_set || (r_underrun && !i_ClrOvr);
    end

    assign o_Underrun = r_underrun;
`endif

    assign o_WrEn    = w_push_acc;
    assign o_WrPtr   = r_wr_ptr;
    assign o_RdPtr   = r_rd_ptr;
    assign o_Full    = w_full;
    assign o_Empty   = w_empty;
    assign o_Level   = r_level;
    assign o_Thresh  = (r_level >= LVL_W'(THRESH));
    assign o_Overrun = r_overrun;

endmodule

// File: rtl/rx_fifo_reg.sv
// Receive data FIFO (first-word-fall-through) between the USRT shifter and the bus.
// Define RX_FIFO_UNDERRUN_EN to expose the sticky o_Underrun flag.
module rx_fifo_reg
    import rx_fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int THRESH = THRESH_DEF
) (
    input  logic                      i_Pclk,
    input  logic                      i_Reset_n,
    input  logic                      i_Push,
    input  logic [DATA_W-1:0]         i_Data,
    input  logic                      i_Pop,
    input  logic                      i_ClrOvr,
    output logic [DATA_W-1:0]         o_Data,
    output logic                      o_Full,
    output logic                      o_Empty,
    output logic [level_w(DEPTH)-1:0] o_Level,
    output logic                      o_Thresh,
`ifdef RX_FIFO_UNDERRUN_EN
    output logic                      o_Underrun,
`endif
    output logic                      o_Overrun
);

    localparam int PTR_W = $clog2(DEPTH);

    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_ptr;
    logic [PTR_W-1:0]  w_rd_ptr;
    logic [DATA_W-1:0] r_mem [DEPTH];

    rx_fifo_ctrl #(
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) u_ctrl (
        .i_Pclk     (i_Pclk),
        .i_Reset_n  (i_Reset_n),
        .i_Push     (i_Push),
        .i_Pop      (i_Pop),
        .i_ClrOvr   (i_ClrOvr),
        .o_WrEn     (w_wr_en),
        .o_WrPtr    (w_wr_ptr),
        .o_RdPtr    (w_rd_ptr),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Level    (o_Level),
        .o_Thresh   (o_Thresh),
`ifdef RX_FIFO_UNDERRUN_EN
        .o_Underrun (o_Underrun),
`endif
        .o_Overrun  (o_Overrun)
    );

    // NOTE: storage has no reset; the empty flag masks stale contents, so clearing it buys nothing.
    always_ff @(posedge i_Pclk) begin
        if (w_wr_en) r_mem[w_wr_ptr] <= i_Data;
    end

    assign o_Data = o_Empty ? '0 : r_mem[w_rd_ptr];

endmodule

// File: tb/tb_rx_fifo_reg.sv
// Directed self-checking bench for rx_fifo_reg (DEPTH=4, THRESH=2).
// Build with RX_FIFO_UNDERRUN_EN defined to also check o_Underrun.
module tb_rx_fifo_reg;

    logic       clk;
    logic       rst_n;
    logic       i_Push;
    logic [7:0] i_Data;
    logic       i_Pop;
    logic       i_ClrOvr;
    logic [7:0] o_Data;
    logic       o_Full;
    logic       o_Empty;
    logic [2:0] o_Level;
    logic       o_Thresh;
    logic       o_Overrun;
`ifdef RX_FIFO_UNDERRUN_EN
    logic       o_Underrun;
`endif

    int n_pass  = 0;
    int n_total = 0;

    rx_fifo_reg #(
        .DATA_W (8),
        .DEPTH  (4),
        .THRESH (2)
    ) dut (
        .i_Pclk     (clk),
        .i_Reset_n  (rst_n),
        .i_Push     (i_Push),
        .i_Data     (i_Data),
        .i_Pop      (i_Pop),
        .i_ClrOvr   (i_ClrOvr),
        .o_Data     (o_Data),
        .o_Full     (o_Full),
        .o_Empty    (o_Empty),
        .o_Level    (o_Level),
        .o_Thresh   (o_Thresh),
`ifdef RX_FIFO_UNDERRUN_EN
        .o_Underrun (o_Underrun),
`endif
        .o_Overrun  (o_Overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge, then settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        i_Push   = 1'b0;
        i_Data   = 8'h00;
        i_Pop    = 1'b0;
        i_ClrOvr = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();
        tick();

        // Reset / idle
        check("rst_empty",   32'(o_Empty),   32'd1);
        check("rst_full",    32'(o_Full),    32'd0);
        check("rst_level",   32'(o_Level),   32'd0);
        check("rst_data",    32'(o_Data),    32'h00);
        check("rst_overrun", 32'(o_Overrun), 32'd0);
        check("rst_thresh",  32'(o_Thresh),  32'd0);

        // Two pushes, then two pops
        i_Push = 1'b1; i_Data = 8'h2E;
        tick();
        check("p1_data",   32'(o_Data),   32'h2E);
        check("p1_level",  32'(o_Level),  32'd1);
        check("p1_thresh", 32'(o_Thresh), 32'd0);
        i_Data = 8'h11;
        tick();
        i_Push = 1'b0;
        check("p2_level",  32'(o_Level),  32'd2);
        check("p2_thresh", 32'(o_Thresh), 32'd1);
        check("p2_data",   32'(o_Data),   32'h2E);
        i_Pop = 1'b1;
        tick();
        check("pop1_data",  32'(o_Data),  32'h11);
        check("pop1_level", 32'(o_Level), 32'd1);
        tick();
        i_Pop = 1'b0;
        check("pop2_empty", 32'(o_Empty), 32'd1);
        check("pop2_data",  32'(o_Data),  32'h00);

        // Fill, overrun, drain, clear
        i_Push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_Data = 8'hA1 + 8'(i);
            tick();
        end
        check("fill_full",  32'(o_Full),  32'd1);
        check("fill_level", 32'(o_Level), 32'd4);
        i_Data = 8'hFF;
        tick();
        i_Push = 1'b0;
        check("ovr_flag",  32'(o_Overrun), 32'd1);
        check("ovr_level", 32'(o_Level),   32'd4);
        i_Pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_a%0d", i), 32'(o_Data), 32'(8'hA1 + 8'(i)));
            tick();
        end
        i_Pop = 1'b0;
        check("drain_empty",  32'(o_Empty),   32'd1);
        check("ovr_sticky",   32'(o_Overrun), 32'd1);
        i_ClrOvr = 1'b1;
        tick();
        i_ClrOvr = 1'b0;
        check("ovr_cleared",  32'(o_Overrun), 32'd0);

        // Full FIFO with simultaneous push/pop; exercises pointer wrap
        i_Push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_Data = 8'hB0 + 8'(i);
            tick();
        end
        check("b_full", 32'(o_Full), 32'd1);
        i_Data = 8'hC4; i_Pop = 1'b1;
        check("pp_head", 32'(o_Data), 32'hB0);
        tick();
        i_Push = 1'b0;
        check("pp_level",   32'(o_Level),   32'd4);
        check("pp_overrun", 32'(o_Overrun), 32'd0);
        check("pp_full",    32'(o_Full),    32'd1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap_%0d", i), 32'(o_Data), (i == 3) ? 32'hC4 : 32'(8'hB1 + 8'(i)));
            tick();
        end
        i_Pop = 1'b0;
        check("wrap_empty", 32'(o_Empty), 32'd1);

        // Empty FIFO, simultaneous push/pop: push wins
        i_Push = 1'b1; i_Data = 8'h5A; i_Pop = 1'b1;
        tick();
        i_Push = 1'b0; i_Pop = 1'b0;
        check("ep_level", 32'(o_Level), 32'd1);
        check("ep_data",  32'(o_Data),  32'h5A);
`ifdef RX_FIFO_UNDERRUN_EN
        check("ep_underrun", 32'(o_Underrun), 32'd0);
`endif
        i_Pop = 1'b1;
        tick();
        check("ep_drained", 32'(o_Empty), 32'd1);
        tick();
        i_Pop = 1'b0;
        check("pop_empty_level",   32'(o_Level),   32'd0);
        check("pop_empty_overrun", 32'(o_Overrun), 32'd0);
`ifdef RX_FIFO_UNDERRUN_EN
        check("udr_set", 32'(o_Underrun), 32'd1);
        i_ClrOvr = 1'b1;
        tick();
        i_ClrOvr = 1'b0;
        check("udr_clear", 32'(o_Underrun), 32'd0);
`endif

        // Overrun set beats a simultaneous clear
        i_Push = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_Data = 8'hE0 + 8'(i);
            tick();
        end
        i_Data = 8'hEE; i_ClrOvr = 1'b1;
        tick();
        i_Push = 1'b0; i_ClrOvr = 1'b0;
        check("setwins_ovr",   32'(o_Overrun), 32'd1);
        check("setwins_level", 32'(o_Level),   32'd4);
        i_Pop = 1'b1;
        tick();
        i_Pop = 1'b0;
        check("e_level3", 32'(o_Level), 32'd3);
        check("e_head",   32'(o_Data),  32'hE1);

        // Asynchronous reset mid-cycle with three words held
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_empty",   32'(o_Empty),   32'd1);
        check("arst_level",   32'(o_Level),   32'd0);
        check("arst_data",    32'(o_Data),    32'h00);
        check("arst_overrun", 32'(o_Overrun), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        i_Push = 1'b1; i_Data = 8'h77;
        tick();
        i_Push = 1'b0;
        check("post_rst_data",  32'(o_Data),  32'h77);
        check("post_rst_level", 32'(o_Level), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
